ab8016_arb: RTL and testbench

AB8016_ARB -- requirements
Module: ab8016_arb

---
 rtl/ab8016_arb_if.sv | 21 ++
 rtl/ab8016_arb.sv | 88 ++++++++
 tb/tb_ab8016_arb.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ab8016_arb_if.sv
// ab8016_arb_if: two-requester access bus plus single-port RAM signals for ab8016_arb.
// The arbiter takes the slave side; requesters and the RAM sit on the master side.
interface ab8016_arb_if;
    logic        req0, req1, wr0, wr1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic        init_done;
    logic        ram_cen, ram_rw;
    logic [7:0]  ram_a;
    logic [15:0] ram_din, ram_dout;
    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_dout,
        output ack0, ack1, rvalid0, rvalid1, rdata, init_done, ram_cen, ram_rw, ram_a, ram_din
    );
    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_dout,
        input  ack0, ack1, rvalid0, rvalid1, rdata, init_done, ram_cen, ram_rw, ram_a, ram_din
    );
endinterface

// File: rtl/ab8016_arb.sv
// ab8016_arb: clears a 256x16 RAM after reset, then arbitrates two requesters onto it
// round-robin, one access per cycle, with reads returning data two cycles after accept.
module ab8016_arb (
    input  logic        sys_clk,
    input  logic        resetl,
    ab8016_arb_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, ram_a_q, ram_a_d;
    logic [15:0] ram_din_q, ram_din_d;
    logic        init_done_q, init_done_d, ram_cen_q, ram_cen_d, ram_rw_q, ram_rw_d, last_q, last_d;
    logic [1:0]  pend_q, pend_d, rvalid_q, rvalid_d, ack;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        ram_cen_d   = 1'b1;
        ram_rw_d    = 1'b1;
        ram_a_d     = ram_a_q;
        ram_din_d   = ram_din_q;
        last_d      = last_q;
        pend_d      = 2'b00;
        rvalid_d    = pend_q;
        ack         = 2'b00;
        if (state_q == INIT) begin
            ram_cen_d = 1'b0;
            ram_rw_d  = 1'b0;
            ram_a_d   = cnt_q;
            ram_din_d = 16'h0000;
            cnt_d     = cnt_q + 8'd1;
            if (cnt_q == 8'hFF) begin
                state_d     = RUN;
                init_done_d = 1'b1;
            end
        end else begin
            // contention goes to whoever was not granted last
            ack[0] = resetl & bus.req0 & (~bus.req1 | last_q);
            ack[1] = resetl & bus.req1 & (~bus.req0 | ~last_q);
            if (|ack) begin
                ram_cen_d = 1'b0;
                ram_rw_d  = ack[1] ? ~bus.wr1 : ~bus.wr0;
                ram_a_d   = ack[1] ? bus.addr1 : bus.addr0;
                ram_din_d = ack[1] ? bus.wdata1 : bus.wdata0;
                last_d    = ack[1];
                pend_d    = ack & {~bus.wr1, ~bus.wr0};
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state_q     <= INIT;
            cnt_q       <= 8'h00;
            init_done_q <= 1'b0;
            ram_cen_q   <= 1'b1;
            ram_rw_q    <= 1'b1;
            ram_a_q     <= 8'h00;
            ram_din_q   <= 16'h0000;
            last_q      <= 1'b1;
            pend_q      <= 2'b00;
            rvalid_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            ram_cen_q   <= ram_cen_d;
            ram_rw_q    <= ram_rw_d;
            ram_a_q     <= ram_a_d;
            ram_din_q   <= ram_din_d;
            last_q      <= last_d;
            pend_q      <= pend_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign bus.ack0      = ack[0];
    assign bus.ack1      = ack[1];
    assign bus.rvalid0   = rvalid_q[0];
    assign bus.rvalid1   = rvalid_q[1];
    assign bus.rdata     = bus.ram_dout;
    assign bus.init_done = init_done_q;
    assign bus.ram_cen   = ram_cen_q;
    assign bus.ram_rw    = ram_rw_q;
    assign bus.ram_a     = ram_a_q;
    assign bus.ram_din   = ram_din_q;
endmodule

// File: tb/tb_ab8016_arb.sv
// tb_ab8016_arb: drives directed and random traffic into ab8016_arb with a RAM model attached,
// and compares every cycle against a queue-based reference of the arbiter's behaviour.
module tb_ab8016_arb;
    logic clk = 1'b0;
    logic resetl = 1'b0;
    ab8016_arb_if bus();

    ab8016_arb dut (.sys_clk(clk), .resetl(resetl), .bus(bus));

    always #5 clk = ~clk;

    logic [15:0] ram [256];
    bit          ram_seeded = 1'b0;
    always @(posedge clk) begin
        if (!ram_seeded) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'($urandom);
            ram_seeded <= 1'b1;
        end else if (!bus.ram_cen) begin
            if (bus.ram_rw) bus.ram_dout <= ram[bus.ram_a];
            else ram[bus.ram_a] <= bus.ram_din;
        end
    end

    typedef struct {
        int          due;
        bit          who;
        logic [15:0] d;
    } rd_t;

    int          checks = 0, errors = 0, cyc = 0, init_cnt = 0;
    bit          run_m = 1'b0, done_m = 1'b0, last_m = 1'b1;
    bit          a0, a1, acc0_last = 1'b0, acc1_last = 1'b0;
    bit          e_cen = 1'b1, e_rw = 1'b1;
    logic [7:0]  e_a = 8'h00;
    logic [15:0] e_din = 16'h0000;
    logic [15:0] ref_mem [256];
    rd_t         rq[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        bit          g, wr, r0, r1;
        logic [7:0]  ad;
        logic [15:0] wd, rd_exp;
        #1;
        a0 = resetl && run_m && bus.req0 && (!bus.req1 || last_m);
        a1 = resetl && run_m && bus.req1 && (!bus.req0 || !last_m);
        chk("ack0", bus.ack0, a0);
        chk("ack1", bus.ack1, a1);
        @(posedge clk);
        cyc++;
        if (!resetl) begin
            init_cnt = 0; run_m = 0; done_m = 0; last_m = 1;
            e_cen = 1; e_rw = 1; e_a = 8'h00; e_din = 16'h0000;
            rq.delete();
        end else if (!run_m) begin
            e_cen = 0; e_rw = 0; e_a = init_cnt[7:0]; e_din = 16'h0000;
            ref_mem[init_cnt] = 16'h0000;
            if (init_cnt == 255) begin
                run_m = 1; done_m = 1;
            end
            init_cnt++;
        end else if (a0 || a1) begin
            g  = a1;
            wr = g ? bus.wr1 : bus.wr0;
            ad = g ? bus.addr1 : bus.addr0;
            wd = g ? bus.wdata1 : bus.wdata0;
            e_cen = 0; e_rw = !wr; e_a = ad; e_din = wd; last_m = g;
            if (wr) ref_mem[ad] = wd;
            else rq.push_back('{cyc + 1, g, ref_mem[ad]});
        end else begin
            e_cen = 1; e_rw = 1;
        end
        acc0_last = a0;
        acc1_last = a1;
        @(negedge clk);
        chk("ram_cen", bus.ram_cen, e_cen);
        chk("ram_rw", bus.ram_rw, e_rw);
        chk("ram_a", bus.ram_a, e_a);
        chk("ram_din", bus.ram_din, e_din);
        chk("init_done", bus.init_done, done_m);
        r0 = 0; r1 = 0; rd_exp = 16'h0000;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r0 = !rq[0].who; r1 = rq[0].who; rd_exp = rq[0].d;
            void'(rq.pop_front());
            chk("rdata", bus.rdata, rd_exp);
        end
        chk("rvalid0", bus.rvalid0, r0);
        chk("rvalid1", bus.rvalid1, r1);
    endtask

    task automatic set_req(bit r0, bit w0, logic [7:0] ad0, logic [15:0] d0,
                           bit r1, bit w1, logic [7:0] ad1, logic [15:0] d1);
        bus.req0 = r0; bus.wr0 = w0; bus.addr0 = ad0; bus.wdata0 = d0;
        bus.req1 = r1; bus.wr1 = w1; bus.addr1 = ad1; bus.wdata1 = d1;
    endtask

    task automatic idle(int n);
        set_req(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        for (int i = 0; i < n; i++) tick();
    endtask

    // an unaccepted request is held unchanged until it is granted
    task automatic rnd(int p);
        if (!(bus.req0 && !acc0_last)) begin
            bus.req0 = $urandom_range(99) < p; bus.wr0 = 1'($urandom);
            bus.addr0 = 8'($urandom_range(15)); bus.wdata0 = 16'($urandom);
        end
        if (!(bus.req1 && !acc1_last)) begin
            bus.req1 = $urandom_range(99) < p; bus.wr1 = 1'($urandom);
            bus.addr1 = 8'($urandom_range(15)); bus.wdata1 = 16'($urandom);
        end
        resetl = $urandom_range(999) != 0;
    endtask

    initial begin
        set_req(1, 0, 8'h5A, 16'h0000, 0, 0, 8'h00, 16'h0000);
        for (int i = 0; i < 3; i++) tick();
        resetl = 1'b1;
        for (int i = 0; i < 257; i++) tick();
        idle(3);
        set_req(1, 1, 8'h12, 16'hBEEF, 0, 0, 8'h00, 16'h0000);
        tick();
        set_req(1, 0, 8'h12, 16'h0000, 0, 0, 8'h00, 16'h0000);
        tick();
        idle(3);
        set_req(1, 1, 8'h01, 16'h1111, 1, 1, 8'h02, 16'h2222);
        for (int i = 0; i < 2; i++) tick();
        set_req(1, 0, 8'h01, 16'h0000, 1, 0, 8'h02, 16'h0000);
        for (int i = 0; i < 6; i++) tick();
        idle(3);
        for (int i = 0; i < 16; i++) begin
            set_req(0, 0, 8'h00, 16'h0000, 1, 1, 8'(i), 16'(16'hA000 + i));
            tick();
        end
        idle(2);
        set_req(1, 0, 8'h03, 16'h0000, 0, 0, 8'h00, 16'h0000);
        tick();
        resetl = 1'b0;
        idle(1);
        resetl = 1'b1;
        idle(260);
        for (int i = 0; i < 2000; i++) begin
            rnd(60);
            tick();
        end
        resetl = 1'b1;
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
